// File: rtl/mem_arb_pkg.sv
// Shared encodings for the cache/memory arbiter: FSM states, owner ids and block alignment.
package mem_arb_pkg;

  localparam int unsigned BLOCK_OFFSET_W    = 5;
  localparam int unsigned BLOCK_OFFSET_MASK = (1 << BLOCK_OFFSET_W) - 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WB   = 2'd1;
  localparam logic [1:0] ST_RD   = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic OWN_IC = 1'b0;
  localparam logic OWN_DC = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Two-requester picker. MEM_ARB_RR_EN selects round-robin on ties, else dcache wins.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic ic_req,
  input  logic dc_req,
  input  logic last_owner,
  output logic grant_c,
  output logic owner_c
);

`ifdef MEM_ARB_RR_EN
  always_comb begin
    grant_c = ic_req | dc_req;
    owner_c = OWN_IC;
    if (ic_req && dc_req) begin
      owner_c = !last_owner;
    end else if (dc_req) begin
      owner_c = OWN_DC;
    end
  end
`else
  logic unused_last_owner;
  assign unused_last_owner = last_owner;

  always_comb begin
    grant_c = ic_req | dc_req;
    owner_c = OWN_IC;
    if (dc_req) begin
      owner_c = OWN_DC;
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the backing memory between icache refills and dcache write-back + refill.
// Optional round-robin tie-breaking with MEM_ARB_RR_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned BLOCK_W = 256,
  parameter int unsigned MEM_TMO = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ic_req,
  input  logic [ADDR_W-1:0]  ic_addr,
  output logic               ic_done,
  output logic [BLOCK_W-1:0] ic_rdata,
  input  logic               dc_req,
  input  logic [ADDR_W-1:0]  dc_addr,
  input  logic               dc_dirty,
  input  logic [ADDR_W-1:0]  dc_wb_addr,
  input  logic [BLOCK_W-1:0] dc_wb_data,
  output logic               dc_done,
  output logic [BLOCK_W-1:0] dc_rdata,
  output logic               mem_req,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [BLOCK_W-1:0] mem_wdata,
  input  logic [BLOCK_W-1:0] mem_rdata,
  input  logic               mem_ready
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BLOCK_OFFSET_MASK);

  logic [31:0] unused_tmo;
  assign unused_tmo = 32'(MEM_TMO);

  logic [1:0]         state_q, state_d;
  logic               owner_q, owner_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ADDR_W-1:0]  wb_addr_q, wb_addr_d;
  logic [BLOCK_W-1:0] wb_data_q, wb_data_d;

  logic               mem_req_d, mem_we_d, ic_done_d, dc_done_d;
  logic [ADDR_W-1:0]  mem_addr_d;
  logic [BLOCK_W-1:0] mem_wdata_d, ic_rdata_d, dc_rdata_d;

  logic grant_c, pick_owner_c, last_owner_c, ready_c;

`ifdef MEM_ARB_RR_EN
  logic last_owner_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_owner_q <= OWN_IC;
    end else if (state_q == ST_DONE) begin
      last_owner_q <= ~last_owner_q;
    end
  end

  assign last_owner_c = last_owner_q;
`else
  assign last_owner_c = OWN_IC;
`endif

  mem_arb_pick u_pick (
    .ic_req     (ic_req),
    .dc_req     (dc_req),
    .last_owner (last_owner_c),
    .grant_c    (grant_c),
    .owner_c    (pick_owner_c)
  );

  // A completion only counts while an access is actually being strobed.
  assign ready_c = mem_ready & mem_req;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
    mem_req_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    ic_done_d   = 1'b0;
    dc_done_d   = 1'b0;
    ic_rdata_d  = ic_rdata;
    dc_rdata_d  = dc_rdata;

    case (state_q)
      ST_IDLE: begin
        if (grant_c) begin
          owner_d   = pick_owner_c;
          mem_req_d = 1'b1;
          if (pick_owner_c == OWN_DC) begin
            addr_d    = dc_addr & ALIGN_MASK;
            wb_addr_d = dc_wb_addr & ALIGN_MASK;
            wb_data_d = dc_wb_data;
          end else begin
            addr_d = ic_addr & ALIGN_MASK;
          end
          if ((pick_owner_c == OWN_DC) && dc_dirty) begin
            state_d     = ST_WB;
            mem_we_d    = 1'b1;
            mem_addr_d  = wb_addr_d;
            mem_wdata_d = wb_data_d;
          end else begin
            state_d    = ST_RD;
            mem_addr_d = addr_d;
          end
        end
      end
      ST_WB: begin
        if (ready_c) begin
          state_d = ST_RD;
        end else begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = wb_addr_q;
          mem_wdata_d = wb_data_q;
        end
      end
      ST_RD: begin
        if (ready_c) begin
          state_d = ST_DONE;
          if (owner_q == OWN_DC) begin
            dc_rdata_d = mem_rdata;
          end else begin
            ic_rdata_d = mem_rdata;
          end
        end else begin
          // Re-raises the strobe after the write-back gap cycle.
          mem_req_d  = 1'b1;
          mem_addr_d = addr_q;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        ic_done_d = (owner_q == OWN_IC);
        dc_done_d = (owner_q == OWN_DC);
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_IC;
      addr_q    <= '0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ic_done   <= 1'b0;
      dc_done   <= 1'b0;
      ic_rdata  <= '0;
      dc_rdata  <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      mem_req   <= mem_req_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      ic_done   <= ic_done_d;
      dc_done   <= dc_done_d;
      ic_rdata  <= ic_rdata_d;
      dc_rdata  <= dc_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model, directed cases and random traffic.
module tb_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned BW = 256;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ic_req, dc_req, dc_dirty;
  logic [AW-1:0] ic_addr, dc_addr, dc_wb_addr;
  logic [BW-1:0] dc_wb_data;
  logic          ic_done, dc_done, mem_req, mem_we;
  logic [BW-1:0] ic_rdata, dc_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [BW-1:0] mem_rdata = '0;
  logic          mem_ready = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .BLOCK_W(BW), .MEM_TMO(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_done(ic_done), .ic_rdata(ic_rdata),
    .dc_req(dc_req), .dc_addr(dc_addr), .dc_dirty(dc_dirty), .dc_wb_addr(dc_wb_addr),
    .dc_wb_data(dc_wb_data), .dc_done(dc_done), .dc_rdata(dc_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  int checks = 0;
  int failures = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [BW-1:0] data;
  } acc_t;

  // Reference model: each grant becomes a list of block accesses, then one done pulse.
  function automatic logic pick(input logic i, input logic d, input logic last);
    if (i && d) return RR ? !last : 1'b1;
    return d;
  endfunction

  acc_t          accq[$];
  int            ph;
  logic          m_owner, m_last;
  logic          exp_mem_req, exp_mem_we, exp_ic_done, exp_dc_done;
  logic [AW-1:0] exp_addr;
  logic [BW-1:0] exp_wdata, exp_ic_rdata, exp_dc_rdata;

  task automatic issue_head();
    exp_mem_req = 1'b1;
    exp_mem_we  = accq[0].we;
    exp_addr    = accq[0].addr;
    exp_wdata   = accq[0].data;
    ph = 1;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      accq.delete();
      ph = 0; m_owner = 1'b0; m_last = 1'b0;
      exp_mem_req = 1'b0; exp_mem_we = 1'b0; exp_addr = '0; exp_wdata = '0;
      exp_ic_done = 1'b0; exp_dc_done = 1'b0; exp_ic_rdata = '0; exp_dc_rdata = '0;
    end else begin
      exp_ic_done = 1'b0;
      exp_dc_done = 1'b0;
      case (ph)
        0: if (ic_req || dc_req) begin
          m_owner = pick(ic_req, dc_req, m_last);
          if (m_owner && dc_dirty)
            accq.push_back('{we: 1'b1, addr: dc_wb_addr & ~32'h1f, data: dc_wb_data});
          accq.push_back('{we: 1'b0, addr: (m_owner ? dc_addr : ic_addr) & ~32'h1f, data: '0});
          issue_head();
        end
        1: if (mem_ready) begin
          if (!accq[0].we) begin
            if (m_owner) exp_dc_rdata = mem_rdata;
            else         exp_ic_rdata = mem_rdata;
          end
          void'(accq.pop_front());
          exp_mem_req = 1'b0;
          exp_mem_we  = 1'b0;
          ph = (accq.size() != 0) ? 2 : 3;
        end
        2: issue_head();
        default: begin
          if (m_owner) exp_dc_done = 1'b1;
          else         exp_ic_done = 1'b1;
          m_last = !m_last;
          ph = 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_n && check_en) begin
      chk("mem_req", mem_req, exp_mem_req);
      chk("mem_we", mem_we, exp_mem_we);
      if (exp_mem_req) chk("mem_addr", mem_addr, exp_addr);
      if (exp_mem_req && exp_mem_we) chk("mem_wdata", mem_wdata, exp_wdata);
      chk("ic_done", ic_done, exp_ic_done);
      chk("dc_done", dc_done, exp_dc_done);
      chk("ic_rdata", ic_rdata, exp_ic_rdata);
      chk("dc_rdata", dc_rdata, exp_dc_rdata);
    end
  end

  // Memory: answers each strobe after mem_lat cycles (random when negative) with a one-cycle ready.
  int      mem_lat = 3;
  bit      mem_fix = 1'b1;
  logic [BW-1:0] mem_fix_data = '0;
  bit      mem_busy = 1'b0;
  int      mem_cnt = 0;
  int      rdy_cnt = 0;
  int      stray_req_cnt = 0, stray_done_cnt = 0;
  time     last_rdy_time = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      mem_ready = 1'b0;
      mem_busy  = 1'b0;
    end else if (mem_ready) begin
      mem_ready = 1'b0;
      mem_busy  = 1'b0;
    end else if (stray_req_cnt != stray_done_cnt && !mem_busy && !mem_req) begin
      stray_done_cnt++;
      mem_ready = 1'b1;
      mem_busy  = 1'b1;
    end else begin
      if (!mem_busy && mem_req) begin
        mem_busy = 1'b1;
        mem_cnt  = (mem_lat < 0) ? int'($urandom_range(4)) : mem_lat;
      end
      if (mem_busy) begin
        if (mem_cnt == 0) begin
          mem_ready = 1'b1;
          if (mem_fix) mem_rdata = mem_fix_data;
          else for (int i = 0; i < 8; i++) mem_rdata[i*32 +: 32] = $urandom;
          rdy_cnt++;
          last_rdy_time = $time;
        end else begin
          mem_cnt--;
        end
      end
    end
  end

  acc_t acc_log[$];
  logic prev_req = 1'b0;
  int   ic_done_cnt = 0, dc_done_cnt = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_req && !prev_req) acc_log.push_back('{we: mem_we, addr: mem_addr, data: mem_wdata});
      if (ic_done) ic_done_cnt++;
      if (dc_done) dc_done_cnt++;
    end
    prev_req = mem_req;
  end

  task automatic wait_done(input bit dc, input int budget, output int cyc);
    cyc = 0;
    while (cyc < budget) begin
      @(negedge clk);
      cyc++;
      if ((dc ? dc_done : ic_done) === 1'b1) return;
    end
    cyc = -1;
  endtask

  task automatic step_rand();
    if (ic_req) begin
      if (ic_done || $urandom_range(63) == 0) ic_req = 1'b0;
    end else if ($urandom_range(3) == 0) begin
      ic_req = 1'b1; ic_addr = $urandom;
    end
    if (dc_req) begin
      if (dc_done || $urandom_range(63) == 0) dc_req = 1'b0;
    end else if ($urandom_range(3) == 0) begin
      dc_req = 1'b1; dc_addr = $urandom; dc_dirty = 1'($urandom_range(1));
      dc_wb_addr = $urandom;
      for (int i = 0; i < 8; i++) dc_wb_data[i*32 +: 32] = $urandom;
    end
  endtask

  task automatic tie_case(input logic [AW-1:0] ia, input logic [AW-1:0] da);
    int start, n;
    logic [AW-1:0] first_exp;
    first_exp = (RR && m_last) ? ia : da;
    if (!RR) first_exp = da;
    start = acc_log.size();
    ic_addr = ia; dc_addr = da; dc_dirty = 1'b0;
    ic_req = 1'b1; dc_req = 1'b1;
    n = 0;
    while ((ic_req || dc_req) && n < 80) begin
      @(negedge clk);
      n++;
      if (ic_done) ic_req = 1'b0;
      if (dc_done) dc_req = 1'b0;
    end
    chk("tie_timeout", 1'(ic_req || dc_req), 1'b0);
    chk("tie_acc_count", acc_log.size() - start, 2);
    if (acc_log.size() >= start + 2) begin
      chk("tie_first", acc_log[start].addr, first_exp);
      chk("tie_second", acc_log[start+1].addr, (first_exp == da) ? ia : da);
    end
  endtask

  initial begin
    int cyc, start, r0, d0, i0;
    time t_done;
    bit found;
    rst_n = 1'b0;
    ic_req = 1'b0; ic_addr = '0; dc_req = 1'b0; dc_addr = '0;
    dc_dirty = 1'b0; dc_wb_addr = '0; dc_wb_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, '0);
    chk("rst_mem_wdata", mem_wdata, '0);
    chk("rst_ic_done", ic_done, 1'b0);
    chk("rst_dc_done", dc_done, 1'b0);
    chk("rst_ic_rdata", ic_rdata, '0);
    chk("rst_dc_rdata", dc_rdata, '0);
    #2 rst_n = 1'b1;
    check_en = 1'b1;
    @(negedge clk);

    // icache read, memory latency 3: done seen 6 negedges after raising req
    mem_fix_data = {32{8'hA5}};
    start = acc_log.size(); d0 = dc_done_cnt; i0 = ic_done_cnt;
    ic_addr = 32'h0000_1234; ic_req = 1'b1;
    wait_done(1'b0, 50, cyc);
    ic_req = 1'b0;
    chk("ic_latency", cyc, 6);
    chk("ic_rdata_val", ic_rdata, {32{8'hA5}});
    @(negedge clk); #1;
    chk("ic_done_single", ic_done, 1'b0);
    chk("ic_done_count", ic_done_cnt - i0, 1);
    chk("ic_no_dc_done", dc_done_cnt - d0, 0);
    chk("ic_acc_count", acc_log.size() - start, 1);
    if (acc_log.size() > start) begin
      chk("ic_mem_addr", acc_log[start].addr, 32'h0000_1220);
      chk("ic_mem_we", acc_log[start].we, 1'b0);
    end

    // dirty dcache miss: write 0x80 then read 0x100
    mem_lat = 2; mem_fix_data = {32{8'h5A}};
    start = acc_log.size(); r0 = rdy_cnt;
    dc_addr = 32'h100; dc_wb_addr = 32'h80; dc_wb_data = {8{32'hDEAD_BEEF}};
    dc_dirty = 1'b1; dc_req = 1'b1;
    wait_done(1'b1, 60, cyc);
    t_done = $time;
    dc_req = 1'b0; dc_dirty = 1'b0;
    chk("dc_done_seen", 1'(cyc > 0), 1'b1);
    chk("dc_done_after_ready", t_done - last_rdy_time, 20);
    chk("dc_rdata_val", dc_rdata, {32{8'h5A}});
    @(negedge clk); #1;
    chk("dc_ready_count", rdy_cnt - r0, 2);
    chk("dc_acc_count", acc_log.size() - start, 2);
    if (acc_log.size() >= start + 2) begin
      chk("dc_wb_we", acc_log[start].we, 1'b1);
      chk("dc_wb_addr", acc_log[start].addr, 32'h80);
      chk("dc_wb_data", acc_log[start].data, {8{32'hDEAD_BEEF}});
      chk("dc_rd_we", acc_log[start+1].we, 1'b0);
      chk("dc_rd_addr", acc_log[start+1].addr, 32'h100);
    end

    // back-to-back ties
    mem_lat = 1;
    tie_case(32'h0000_2040, 32'h0000_3060);
    tie_case(32'h0000_4000, 32'h0000_5000);

    // stray ready while idle
    repeat (3) @(negedge clk);
    i0 = ic_done_cnt; d0 = dc_done_cnt;
    stray_req_cnt++;
    repeat (5) @(negedge clk);
    #1;
    chk("stray_no_ic_done", ic_done_cnt - i0, 0);
    chk("stray_no_dc_done", dc_done_cnt - d0, 0);
    chk("stray_mem_req", mem_req, 1'b0);

    // reset in the middle of a write-back
    mem_lat = 6;
    dc_addr = 32'h100; dc_wb_addr = 32'h80; dc_wb_data = {8{32'h1234_5678}};
    dc_dirty = 1'b1; dc_req = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (mem_req && mem_we) found = 1'b1;
    end
    chk("wb_reached", found, 1'b1);
    d0 = dc_done_cnt;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_mem_req", mem_req, 1'b0);
    chk("rst_mid_mem_we", mem_we, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    start = acc_log.size();
    wait_done(1'b1, 80, cyc);
    dc_req = 1'b0; dc_dirty = 1'b0;
    chk("wb_restart_done", 1'(cyc > 0), 1'b1);
    @(negedge clk); #1;
    chk("wb_restart_done_count", dc_done_cnt - d0, 1);
    if (acc_log.size() > start) begin
      chk("wb_restart_we", acc_log[start].we, 1'b1);
      chk("wb_restart_addr", acc_log[start].addr, 32'h80);
    end else begin
      chk("wb_restart_acc", acc_log.size() - start, 2);
    end

    // random traffic with occasional resets
    mem_lat = -1; mem_fix = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      step_rand();
      if ($urandom_range(599) == 0) begin
        #2 rst_n = 1'b0;
        #1 chk("rand_rst_mem_req", mem_req, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b1;
      end
    end
    ic_req = 1'b0; dc_req = 1'b0;
    repeat (40) @(negedge clk);
    #1 chk("drain_idle", mem_req, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Arbitrates the single block-wide backing memory between the instruction-cache refill port and the data-cache miss port. Sequences each data-cache miss as an optional dirty-victim write-back followed by a block refill. Presents a req/done handshake to each cache and a req/ready handshake to memory. Sits between the two caches and the memory model in the bourgeois core.

Parameters:
ADDR_W, 32, byte address width
BLOCK_W, 256, cache block width in bits (32-byte block, 5 offset bits)
MEM_TMO, 64, memory-timeout cycle limit (used only with the optional feature)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
ic_req  in  1  icache refill request, held high until ic_done
ic_addr  in  ADDR_W  icache miss address; bits [4:0] ignored
ic_done  out  1  one-cycle pulse, ic_rdata valid
ic_rdata  out  BLOCK_W  refilled block
dc_req  in  1  dcache miss request, held high until dc_done
dc_addr  in  ADDR_W  dcache miss address; bits [4:0] ignored
dc_dirty  in  1  victim is dirty, write-back required
dc_wb_addr  in  ADDR_W  victim block address
dc_wb_data  in  BLOCK_W  victim block data
dc_done  out  1  one-cycle pulse, dc_rdata valid
dc_rdata  out  BLOCK_W  refilled block
mem_req  out  1  memory access strobe
mem_we  out  1  1 = block write, 0 = block read
mem_addr  out  ADDR_W  block-aligned address, low 5 bits forced to 0
mem_wdata  out  BLOCK_W  write data
mem_rdata  in  BLOCK_W  read data, valid with mem_ready
mem_ready  in  1  one-cycle completion pulse from memory

Behaviour:
- All outputs are registered. Reset value of every output is 0.
- State machine: IDLE -> WB -> RD -> DONE -> IDLE.
- IDLE: choose an owner among asserted requests. Default policy is fixed priority, dcache over icache.
  - dcache owner with dc_dirty=1: latch dc_addr, dc_wb_addr, dc_wb_data, go to WB.
  - Otherwise latch the requesting address and go to RD.
- WB: drive mem_req=1, mem_we=1, mem_addr=wb_addr&~31, mem_wdata=latched data. Hold until mem_ready, then go to RD.
- RD: drive mem_req=1, mem_we=0, mem_addr=addr&~31. On mem_ready, capture mem_rdata into the owner's rdata register and go to DONE.
- DONE: pulse the owner's done for 1 cycle; the rdata register holds until the next completion for that port. Return to IDLE.
- mem_req drops in the same cycle mem_ready is sampled; mem_we is 0 whenever mem_req=0.
- Latency, no write-back, memory answering N cycles after mem_req rises: done asserts N+2 cycles after req is sampled in IDLE.
- A requester that drops req before done: the transaction still completes and done still pulses; the requester ignores it.
- New requests are ignored while not in IDLE; a req held through DONE is arbitrated in the following IDLE cycle.
- Simultaneous ic_req and dc_req: one grant only. The loser stays pending with no side effects.
- mem_ready outside WB/RD is ignored.
- Reset mid-transaction: FSM goes to IDLE, mem_req goes low, no done is issued, and the partial request is lost (caches re-request).

Optional Feature:
MEM_ARB_RR_EN
- Defined: round-robin. A 1-bit last_owner register (reset 0 = icache) flips on each DONE. On a tie, the port that was not last_owner wins.
- Undefined: fixed priority, dcache wins every tie, and no last_owner register is built.

Decomposition:
- Shared package mem_arb_pkg: state encoding (IDLE=2'd0, WB=2'd1, RD=2'd2, DONE=2'd3), owner encoding (OWN_IC=0, OWN_DC=1), BLOCK_OFFSET_W=5, block-align mask.
- Natural sub-module: mem_arb_pick, a combinational two-requester picker taking the req pair and last_owner and returning grant and owner. It contains the RR_EN/fixed-priority difference.
- FSM, latches and output registers stay in mem_arbiter.

Test Plan:
- Reset: rst_n low for 3 cycles, then release -> all outputs 0, FSM IDLE, no mem_req.
- icache read: ic_req, ic_addr=0x0000_1234, memory ready after 3 cycles with rdata=256'hA5... -> mem_addr=0x0000_1220, mem_we=0, ic_done pulses once with ic_rdata=256'hA5..., dc_done stays 0.
- Dirty dcache miss: dc_req, dc_dirty=1, dc_wb_addr=0x80, dc_addr=0x100 -> write at 0x80 with dc_wb_data, then read at 0x100. dc_done follows the second mem_ready by 1 cycle, with exactly two mem_ready-qualified accesses.
- Tie, fixed priority (macro undefined): both reqs in the same cycle -> dcache served first, icache served in the next IDLE.
- Tie, MEM_ARB_RR_EN, two back-to-back ties -> owners alternate DC, IC or IC, DC according to last_owner.
- Reset mid-WB: assert rst_n low while mem_req=1, mem_we=1 -> mem_req goes 0 immediately, no done, and a fresh dc_req restarts from WB.
